// File: rtl/riscv_defs.sv
// Shared RV32I control encodings: opcodes, datapath select codes, FSM state
// enum and a per-opcode decode helper used by the multicycle controller.
package riscv_defs;

    // Base opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Immediate format; shared with immediate_generator
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Next-PC source
    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    // Writeback mux
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    // ALU operand and operation selects
    localparam logic [1:0] ALU_A_RS1     = 2'd0;
    localparam logic [1:0] ALU_A_PC      = 2'd1;
    localparam logic [1:0] ALU_A_ZERO    = 2'd2;
    localparam logic       ALU_B_RS2     = 1'b0;
    localparam logic       ALU_B_IMM     = 1'b1;
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd1;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEM       = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    // Per-opcode class flags plus the EXECUTE-phase datapath selects
    typedef struct packed {
        logic       legal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_fence;
        logic       is_jal;
        logic       is_jalr;
        logic [2:0] imm_sel;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] alu_op_sel;
    } ctrl_t;

    function automatic ctrl_t decode_opcode(input logic [6:0] opc);
        ctrl_t c;
        c = '0;
        case (opc)
            OPC_LUI: begin
                c.legal = 1'b1; c.imm_sel = IMM_U;
                c.alu_a_sel = ALU_A_ZERO; c.alu_b_sel = ALU_B_IMM;
            end
            OPC_AUIPC: begin
                c.legal = 1'b1; c.imm_sel = IMM_U;
                c.alu_a_sel = ALU_A_PC; c.alu_b_sel = ALU_B_IMM;
            end
            OPC_JAL: begin
                c.legal = 1'b1; c.is_jal = 1'b1; c.imm_sel = IMM_J;
            end
            OPC_JALR: begin
                c.legal = 1'b1; c.is_jalr = 1'b1; c.imm_sel = IMM_I;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_IMM;
            end
            OPC_BRANCH: begin
                c.legal = 1'b1; c.is_branch = 1'b1; c.imm_sel = IMM_B;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_RS2;
                c.alu_op_sel = ALU_OP_BRANCH;
            end
            OPC_LOAD: begin
                c.legal = 1'b1; c.is_load = 1'b1; c.imm_sel = IMM_I;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_IMM;
            end
            OPC_STORE: begin
                c.legal = 1'b1; c.is_store = 1'b1; c.imm_sel = IMM_S;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_IMM;
            end
            OPC_OP_IMM: begin
                c.legal = 1'b1; c.imm_sel = IMM_I;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_IMM;
                c.alu_op_sel = ALU_OP_FUNCT;
            end
            OPC_OP: begin
                c.legal = 1'b1;
                c.alu_a_sel = ALU_A_RS1; c.alu_b_sel = ALU_B_RS2;
                c.alu_op_sel = ALU_OP_FUNCT;
            end
            OPC_FENCE: begin
                c.legal = 1'b1; c.is_fence = 1'b1;
            end
            default: c.legal = 1'b0;  // SYSTEM and everything unknown
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for the imem/dmem handshakes. expire flags that the
// current waiting cycle is the TIMEOUT-th one; TIMEOUT=0 never expires.
module mem_wait_timer #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic advance,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Count waiting cycles; clear wins, saturate instead of wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (advance && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expire = 1'b0;
        end else begin : g_timeout
            // count holds the number of waits already seen before this cycle
            assign expire = (count == CNT_W'(TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// datapath selects, memory handshakes and sticky illegal/bus-error traps.
module multicycle_controller
    import riscv_defs::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_a_sel,
    output logic       alu_b_sel,
    output logic [1:0] alu_op_sel,
    output logic       rf_we,
    output logic [1:0] wb_sel,
    output logic       instret,
    output logic       illegal,
    output logic       bus_error
);

    state_t state;
    state_t state_next;
    ctrl_t  ctrl;
    logic   waiting;
    logic   expire;
    logic   trap_illegal;
    logic   trap_bus;

    assign ctrl = decode_opcode(opcode);

    // Counter restarts on every state change, so entry to FETCH/MEM sees 0
    mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state_next != state),
        .advance (waiting),
        .expire  (expire)
    );

    // Next state and datapath controls, decoded from state and opcode
    always_comb begin
        state_next   = state;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS4;
        imm_sel      = IMM_I;
        alu_a_sel    = ALU_A_RS1;
        alu_b_sel    = ALU_B_RS2;
        alu_op_sel   = ALU_OP_ADD;
        rf_we        = 1'b0;
        wb_sel       = WB_ALU;
        instret      = 1'b0;
        waiting      = 1'b0;
        trap_illegal = 1'b0;
        trap_bus     = 1'b0;

        case (state)
            ST_IDLE: state_next = ST_FETCH;

            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we      = 1'b1;
                    state_next = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                    if (expire) begin
                        trap_bus   = 1'b1;
                        state_next = ST_TRAP;
                    end
                end
            end

            ST_DECODE: begin
                if (ctrl.legal) begin
                    state_next = ST_EXECUTE;
                end else begin
                    trap_illegal = 1'b1;
                    state_next   = ST_TRAP;
                end
            end

            ST_EXECUTE: begin
                imm_sel    = ctrl.imm_sel;
                alu_a_sel  = ctrl.alu_a_sel;
                alu_b_sel  = ctrl.alu_b_sel;
                alu_op_sel = ctrl.alu_op_sel;
                if (ctrl.is_branch) begin
                    // Branches and fences retire here without a writeback
                    pc_we      = 1'b1;
                    pc_src     = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    instret    = 1'b1;
                    state_next = ST_FETCH;
                end else if (ctrl.is_fence) begin
                    pc_we      = 1'b1;
                    instret    = 1'b1;
                    state_next = ST_FETCH;
                end else if (ctrl.is_load || ctrl.is_store) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end

            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = ctrl.is_store;
                if (dmem_ready) begin
                    if (ctrl.is_store) begin
                        // Stores retire in the completing cycle
                        pc_we      = 1'b1;
                        instret    = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else begin
                    waiting = 1'b1;
                    if (expire) begin
                        trap_bus   = 1'b1;
                        state_next = ST_TRAP;
                    end
                end
            end

            ST_WRITEBACK: begin
                // The immediate generator is registered, keep its format stable
                imm_sel = ctrl.imm_sel;
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                instret = 1'b1;
                if (ctrl.is_load)                    wb_sel = WB_MEM;
                else if (ctrl.is_jal || ctrl.is_jalr) wb_sel = WB_PC4;
                if (ctrl.is_jal)       pc_src = PC_SRC_IMM;
                else if (ctrl.is_jalr) pc_src = PC_SRC_JALR;
                state_next = ST_FETCH;
            end

            ST_TRAP: state_next = ST_TRAP;

            default: state_next = ST_IDLE;
        endcase
    end

    // State register and sticky trap flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            state <= state_next;
            if (trap_illegal) illegal   <= 1'b1;
            if (trap_bus)     bus_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle stimulus and expected
// output vectors are queued per instruction, then replayed and compared.
module tb_multicycle_controller;

    localparam int TIMEOUT = 4;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] FENCE  = 7'b0001111;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef struct packed {
        logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
        logic [1:0] pc_src;
        logic [2:0] imm_sel;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] alu_op_sel;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic       instret, illegal, bus_error;
    } out_t;

    typedef struct packed {
        logic [6:0] opc;
        logic       ir, dr, bt;
        out_t       exp;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_taken, imem_ready, dmem_ready;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] alu_op_sel;
    logic       rf_we;
    logic [1:0] wb_sel;
    logic       instret, illegal, bus_error;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];

    multicycle_controller #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .pc_src(pc_src), .imm_sel(imm_sel), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .alu_op_sel(alu_op_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .instret(instret), .illegal(illegal), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

    function automatic out_t outs();
        out_t o;
        o.imem_req = imem_req;   o.ir_we = ir_we;       o.dmem_req = dmem_req;
        o.dmem_we = dmem_we;     o.pc_we = pc_we;       o.pc_src = pc_src;
        o.imm_sel = imm_sel;     o.alu_a_sel = alu_a_sel;
        o.alu_b_sel = alu_b_sel; o.alu_op_sel = alu_op_sel;
        o.rf_we = rf_we;         o.wb_sel = wb_sel;     o.instret = instret;
        o.illegal = illegal;     o.bus_error = bus_error;
        return o;
    endfunction

    // Reference EXECUTE-phase selects: {imm, alu_a, alu_b, alu_op}
    function automatic out_t ref_exec(input logic [6:0] opc);
        out_t e;
        e = '0;
        case (opc)
            LUI:    begin e.imm_sel = 3; e.alu_a_sel = 2; e.alu_b_sel = 1; end
            AUIPC:  begin e.imm_sel = 3; e.alu_a_sel = 1; e.alu_b_sel = 1; end
            JAL:    begin e.imm_sel = 4; end
            JALR:   begin e.imm_sel = 0; e.alu_b_sel = 1; end
            BRANCH: begin e.imm_sel = 2; e.alu_op_sel = 2; end
            LOAD:   begin e.imm_sel = 0; e.alu_b_sel = 1; end
            OPIMM:  begin e.imm_sel = 0; e.alu_b_sel = 1; e.alu_op_sel = 1; end
            STORE:  begin e.imm_sel = 1; e.alu_b_sel = 1; end
            OP:     begin e.alu_op_sel = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic push(input logic [6:0] opc, input logic ir, input logic dr,
                        input logic bt, input out_t e);
        ent_t n;
        n.opc = opc; n.ir = ir; n.dr = dr; n.bt = bt; n.exp = e;
        sb.push_back(n);
    endtask

    // Queue one complete legal instruction with fw fetch waits and mw mem waits
    task automatic push_instr(input logic [6:0] opc, input logic bt,
                              input int fw, input int mw);
        out_t e, ex;
        logic ld, st, jl, jr;
        ld = (opc == LOAD); st = (opc == STORE);
        jl = (opc == JAL);  jr = (opc == JALR);
        for (int i = 0; i < fw; i++) begin
            e = '0; e.imem_req = 1; push(opc, 0, 0, bt, e);
        end
        e = '0; e.imem_req = 1; e.ir_we = 1; push(opc, 1, 0, bt, e);
        e = '0; push(opc, 0, 0, bt, e);
        ex = ref_exec(opc);
        e = ex;
        if (opc == BRANCH || opc == FENCE) begin
            e.pc_we = 1; e.instret = 1;
            e.pc_src = (opc == BRANCH && bt) ? 2'd1 : 2'd0;
            push(opc, 0, 0, bt, e);
            return;
        end
        push(opc, 0, 0, bt, e);
        if (ld || st) begin
            for (int i = 0; i < mw; i++) begin
                e = '0; e.dmem_req = 1; e.dmem_we = st; push(opc, 0, 0, bt, e);
            end
            e = '0; e.dmem_req = 1; e.dmem_we = st;
            if (st) begin e.pc_we = 1; e.instret = 1; end
            push(opc, 0, 1, bt, e);
            if (st) return;
        end
        e = '0; e.imm_sel = ex.imm_sel; e.rf_we = 1; e.pc_we = 1; e.instret = 1;
        e.wb_sel = ld ? 2'd1 : ((jl || jr) ? 2'd2 : 2'd0);
        e.pc_src = jl ? 2'd1 : (jr ? 2'd2 : 2'd0);
        push(opc, 0, 0, bt, e);
    endtask

    task automatic push_idle();
        push(7'd0, 0, 0, 0, '0);
    endtask

    task automatic test_reset();
        checks++;
        if (outs() !== '0) begin
            errors++; $display("FAIL reset_hold: got %h expected %h", outs(), 21'h0);
        end
        imem_ready = 1; dmem_ready = 1; opcode = OPIMM;
        @(negedge clk);
        checks++;
        if (outs() !== '0) begin
            errors++; $display("FAIL reset_inputs: got %h expected %h", outs(), 21'h0);
        end
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    task automatic test_alu();
        ent_t e; out_t o; int n = 0;
        push_idle();
        push_instr(OPIMM, 0, 0, 0);
        push_instr(OP,    0, 0, 0);
        push_instr(LUI,   0, 1, 0);
        push_instr(AUIPC, 0, 0, 0);
        push_instr(JAL,   0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL alu cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        ent_t e; out_t o; int n = 0;
        push_instr(BRANCH, 1, 0, 0);
        push_instr(BRANCH, 0, 2, 0);
        push_instr(FENCE,  1, 3, 0);  // imem ready on the TIMEOUT-th cycle
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL branch cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_jalr();
        ent_t e; out_t o; int n = 0;
        push_instr(LOAD, 0, 0, 3);
        push_instr(JALR, 1, 0, 0);
        push_instr(LOAD, 0, 0, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL load_jalr cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_timeout();
        ent_t e; out_t o, x; int n = 0;
        push_instr(STORE, 0, 0, 3);  // dmem ready on the TIMEOUT-th cycle
        x = '0; x.imem_req = 1; x.ir_we = 1; push(STORE, 1, 0, 0, x);
        push(STORE, 0, 0, 0, '0);
        push(STORE, 0, 0, 0, ref_exec(STORE));
        for (int i = 0; i < TIMEOUT; i++) begin
            x = '0; x.dmem_req = 1; x.dmem_we = 1; push(STORE, 0, 0, 0, x);
        end
        for (int i = 0; i < 3; i++) begin
            x = '0; x.bus_error = 1; push(STORE, 1, 1, 1, x);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL dmem_timeout cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        rst_n = 0; #1;
        checks++;
        if (bus_error !== 1'b0) begin
            errors++; $display("FAIL bus_error_clear: got %b expected 0", bus_error);
        end
        @(posedge clk); #1; rst_n = 1;
        // Instruction fetch that never completes
        push_idle();
        for (int i = 0; i < TIMEOUT; i++) begin
            x = '0; x.imem_req = 1; push(OPIMM, 0, 0, 0, x);
        end
        x = '0; x.bus_error = 1; push(OPIMM, 1, 0, 0, x);
        push(OPIMM, 1, 1, 0, x);
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL imem_timeout cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        rst_n = 0; @(posedge clk); #1; rst_n = 1;
    endtask

    task automatic test_illegal();
        ent_t e; out_t o, x; int n = 0;
        push_idle();
        x = '0; x.imem_req = 1; x.ir_we = 1; push(SYSTEM, 1, 0, 0, x);
        push(SYSTEM, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) begin
            x = '0; x.illegal = 1; push(SYSTEM, 1, 1, 1, x);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL illegal cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        rst_n = 0; #1;
        checks++;
        if (illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear: got %b expected 0", illegal);
        end
        @(posedge clk); #1; rst_n = 1;
    endtask

    task automatic test_reset_mid_mem();
        ent_t e; out_t o, x; int n = 0;
        push_idle();
        x = '0; x.imem_req = 1; x.ir_we = 1; push(LOAD, 1, 0, 0, x);
        push(LOAD, 0, 0, 0, '0);
        push(LOAD, 0, 0, 0, ref_exec(LOAD));
        x = '0; x.dmem_req = 1; push(LOAD, 0, 0, 0, x);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL mid_mem cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++; $display("FAIL mid_mem_wait: dmem_req got %b expected 1", dmem_req);
        end
        rst_n = 0; #1;
        checks++;
        if (outs() !== '0) begin
            errors++; $display("FAIL async_reset_drop: got %h expected %h", outs(), 21'h0);
        end
        @(posedge clk); #1; rst_n = 1;
        push_idle();
        push_instr(OPIMM, 0, 0, 0);
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            opcode = e.opc; imem_ready = e.ir; dmem_ready = e.dr; branch_taken = e.bt;
            @(negedge clk);
            o = outs(); checks++;
            if (o !== e.exp) begin
                errors++; $display("FAIL restart cycle %0d: got %h expected %h", n, o, e.exp);
            end
            n++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 0; opcode = '0; branch_taken = 0; imem_ready = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_alu();
        test_branch();
        test_load_jalr();
        test_timeout();
        test_illegal();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
